encoder42_ser: RTL and testbench

ENCODER42_SER -- requirements
Module: encoder42_ser

---
 rtl/encoder42_ser.sv | 158 +++++++++++++++
 tb/tb_encoder42_ser.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/encoder42_ser.sv
// encoder42_ser -- serialising 4-to-2 priority encoder with a valid/ready output.
//
// A non-zero line vector offered on d with load while idle is captured into a
// pending register. Each set line is then reported as a 2-bit code {a,b}, from
// the highest index down, one code per consumer handshake. last marks the
// final code of a captured vector.
//
// Optional feature macro: ENC42_ONEHOT_CHECK_EN
//   defined   : multi-hot loads are rejected and err pulses for one cycle
//   undefined : multi-hot loads are serialised and err is tied to 0
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   d[3:0]     in   line vector (d[3] = code 11)
//   load       in   offer d for capture
//   in_ready   out  block is idle and can capture
//   a, b       out  code MSB / LSB of the line being reported (00 when not valid)
//   code_valid out  {a,b} holds a valid code
//   code_ready in   consumer accepts the current code
//   last       out  current code is the final one of the captured vector
//   err        out  one-cycle rejection pulse
module encoder42_ser (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  input  logic       load,
  output logic       in_ready,
  output logic       a,
  output logic       b,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       last,
  output logic       err
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Index of the highest set line; 00 for an empty vector.
  function automatic logic [1:0] hi_idx(input logic [3:0] v);
    if (v[3]) begin
      return 2'd3;
    end else if (v[2]) begin
      return 2'd2;
    end else if (v[1]) begin
      return 2'd1;
    end else begin
      return 2'd0;
    end
  endfunction

  // True when exactly one line is set.
  function automatic logic is_single(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [1:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
`ifdef ENC42_ONEHOT_CHECK_EN
  logic        err_q, err_d;
`endif

  // Next-state logic; the code outputs are precomputed from the next state so
  // they can be registered and never see d, load or code_ready directly.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
`ifdef ENC42_ONEHOT_CHECK_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (load && (d != 4'b0000)) begin
`ifdef ENC42_ONEHOT_CHECK_EN
          if (!is_single(d)) begin
            err_d = 1'b1;
          end else begin
            pending_d = d;
            state_d   = SHIFT;
          end
`else
          pending_d = d;
          state_d   = SHIFT;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (code_ready) begin
          pending_d = pending_q & ~(4'b0001 << hi_idx(pending_q));
          if (is_single(pending_q)) begin
            state_d = IDLE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 4'b0000;
      end
    endcase

    valid_d = (state_d == SHIFT);
    if (valid_d) begin
      code_d = hi_idx(pending_d);
      last_d = is_single(pending_d);
    end else begin
      code_d = 2'b00;
      last_d = 1'b0;
    end
  end

  // State, pending vector and registered outputs; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      code_q    <= 2'b00;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
`ifdef ENC42_ONEHOT_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
`ifdef ENC42_ONEHOT_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  // in_ready drops as soon as reset is asserted, not only after the edge.
  assign in_ready   = (state_q == IDLE) && !rst;
  assign a          = code_q[1];
  assign b          = code_q[0];
  assign code_valid = valid_q;
  assign last       = last_q;
`ifdef ENC42_ONEHOT_CHECK_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_encoder42_ser.sv
// Testbench for encoder42_ser: directed vectors, expected codes pushed into a
// scoreboard queue by the stimulus, popped and compared by a separate monitor
// on every consumed code.
module tb_encoder42_ser;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d;
  logic       load;
  logic       in_ready;
  logic       a;
  logic       b;
  logic       code_valid;
  logic       code_ready;
  logic       last;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] exp_q[$];  // {a,b,last}

  encoder42_ser dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .load       (load),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .last       (last),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumed-code monitor: a code is consumed when valid and ready meet outside reset.
  always @(negedge clk) begin
    if (code_valid === 1'b1 && code_ready === 1'b1 && rst === 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL extra_code: got {a,b,last}=%b%b%b expected none at %0t", a, b, last, $time);
      end else begin
        check("code", {1'b0, a, b, last}, {1'b0, exp_q.pop_front()});
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; d = 4'b0000; load = 1'b0; code_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_outputs", {a, b, code_valid, last}, 4'b0000);
    check("rst_err", {3'b000, err}, 4'b0000);
    check("rst_in_ready", {3'b000, in_ready}, 4'b0000);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("post_rst_outputs", {a, b, code_valid, last}, 4'b0000);
    check("post_rst_in_ready", {3'b000, in_ready}, 4'b0001);

    // Single line 0100 -> code 10, last, then idle next cycle
    tick(); d = 4'b0100; load = 1'b1; exp_q.push_back(3'b101);
    tick(); load = 1'b0;
    @(negedge clk);
    check("lat1_valid", {3'b000, code_valid}, 4'b0001);
    tick();
    @(negedge clk);
    check("0100_idle", {2'b00, in_ready, code_valid}, 4'b0010);

`ifndef ENC42_ONEHOT_CHECK_EN
    // Multi-hot 1011 -> 11, 01, 00(last) on consecutive cycles
    tick(); d = 4'b1011; load = 1'b1;
    exp_q.push_back(3'b110); exp_q.push_back(3'b010); exp_q.push_back(3'b001);
    tick(); load = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    check("1011_idle", {2'b00, in_ready, code_valid}, 4'b0010);
    check("1011_err", {3'b000, err}, 4'b0000);
    // Multi-hot 0110 -> 10, 01(last)
    tick(); d = 4'b0110; load = 1'b1;
    exp_q.push_back(3'b100); exp_q.push_back(3'b011);
    tick(); load = 1'b0;
    @(negedge clk);
    check("0110_err", {3'b000, err}, 4'b0000);
    tick(); tick();
    @(negedge clk);
    check("0110_idle", {3'b000, in_ready}, 4'b0001);
`else
    // One-hot checking: 0110 rejected, err one cycle, then 1000 accepted
    tick(); d = 4'b0110; load = 1'b1;
    tick(); load = 1'b0;
    @(negedge clk);
    check("reject_err", {2'b00, err, code_valid}, 4'b0010);
    check("reject_in_ready", {3'b000, in_ready}, 4'b0001);
    tick();
    @(negedge clk);
    check("reject_err_end", {2'b00, err, code_valid}, 4'b0000);
    d = 4'b1000; load = 1'b1; exp_q.push_back(3'b111);
    tick(); load = 1'b0;
    tick();
    @(negedge clk);
    check("1000_idle", {3'b000, in_ready}, 4'b0001);
`endif

    // Stall: 0010 held for three cycles with code_ready low
    tick(); code_ready = 1'b0; d = 4'b0010; load = 1'b1; exp_q.push_back(3'b011);
    tick(); load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", {a, b, code_valid, last}, 4'b0111);
      tick();
    end
    code_ready = 1'b1;
    tick();
    @(negedge clk);
    check("stall_idle", {2'b00, in_ready, code_valid}, 4'b0010);

    // Reset during SHIFT after the first code of 1111
    tick(); d = 4'b1111; load = 1'b1; exp_q.push_back(3'b110);
    tick(); load = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", {3'b000, in_ready}, 4'b0000);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {a, b, code_valid, last}, 4'b0000);
    check("rst_mid_in_ready2", {3'b000, in_ready}, 4'b0001);
    tick(); tick();
    @(negedge clk);
    check("rst_mid_discard", {3'b000, code_valid}, 4'b0000);

    // Ignored loads: d=0 in IDLE, d=0001 while in SHIFT
    tick(); d = 4'b0000; load = 1'b1;
    tick(); load = 1'b0;
    @(negedge clk);
    check("zero_load", {1'b0, in_ready, code_valid, err}, 4'b0100);
    d = 4'b1000; load = 1'b1; exp_q.push_back(3'b111);
    tick(); code_ready = 1'b0; d = 4'b0001; load = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("shift_load_hold", {a, b, code_valid, last}, 4'b1111);
    load = 1'b0; code_ready = 1'b1;
    tick();
    @(negedge clk);
    check("shift_load_idle", {1'b0, in_ready, code_valid, err}, 4'b0100);
    tick(); tick();
    @(negedge clk);
    check("no_extra", {3'b000, code_valid}, 4'b0000);

    check("queue_empty", exp_q.size() > 0 ? 4'b0001 : 4'b0000, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
